// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, captures instruction words into a
// 2-entry prefetch buffer and hands {pc, instr} to decode over valid/ready.
module fetch_sequencer #(
    parameter int unsigned MEM_BYTES = 400,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    logic [31:0] buf_pc_mem    [2];
    logic [31:0] buf_instr_mem [2];

    logic push;
    logic pop;
    logic flush;
    logic push_room;
    logic fetch_legal;

    assign out_valid   = (count_q != 2'd0);
    assign pop         = out_valid && out_ready;
    assign push_room   = (count_q != 2'd2) || pop;
    assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else if (!fetch_legal) begin
                    fault_pc_d = pc_q;
                    state_d    = ST_FAULT;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (push_room) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end
                if (start && !halt_req) state_d = ST_RUN;
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The head pop is honoured before a flush empties whatever remains.
    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d values from the same edge regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'd0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: buffer storage is not reset; its contents are only visible
    // through out_* while count_q marks the entry valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_mem[wr_ptr_q]    <= pc_q;
            buf_instr_mem[wr_ptr_q] <= imem_instr;
        end
    end

    assign out_pc    = out_valid ? buf_pc_mem[rd_ptr_q]    : 32'd0;
    assign out_instr = out_valid ? buf_instr_mem[rd_ptr_q] : 32'd0;
    assign imem_addr = pc_q;
    assign fault     = (state_q == ST_FAULT);
    assign fault_pc  = fault_pc_q;
    assign state_o   = state_q;

endmodule
